// File: rtl/player_sprite.sv
// player_sprite
//   Player-ship controller and pixel sequencer for the 160x120 game screen.
//   It holds the ship's top-left position and moves it once per frame_tick,
//   clamped to the screen. It tracks lives, with a blinking invulnerability
//   window after each hit. On draw_req it streams SPRITE_W x SPRITE_H pixels
//   to the VGA write port, one per cycle.
//
// Ports
//   clk, reset_n      clock and synchronous active-low reset
//   frame_tick        one-cycle frame pulse; moves and countdown happen on it
//   left, right       move requests, sampled on frame_tick
//   got_hit           one-cycle hit pulse from the collision checker
//   draw_req          one-cycle pulse that starts a pixel scan
//   x_pos, y_pos      pixel coordinates while plot=1, otherwise base position
//   colour            pixel colour while plot=1, otherwise 0
//   plot              VGA write enable
//   draw_busy         scan in progress
//   draw_done         one-cycle pulse after the last pixel
//   lives_left        remaining lives
//   invuln            invulnerability window active
//   game_over         lives exhausted, sticky until reset
module player_sprite #(
  parameter int          SPRITE_W      = 4,
  parameter int          SPRITE_H      = 4,
  parameter int          SCREEN_W      = 160,
  parameter int          START_X       = 78,
  parameter int          START_Y       = 100,
  parameter int          STEP          = 1,
  parameter int          LIVES         = 3,
  parameter int          INVULN_FRAMES = 60,
  parameter logic [2:0]  COLOUR        = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       got_hit,
  input  logic       draw_req,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_busy,
  output logic       draw_done,
  output logic [3:0] lives_left,
  output logic       invuln,
  output logic       game_over
);

  typedef enum logic [1:0] {
    LIFE_ALIVE  = 2'd0,
    LIFE_INVULN = 2'd1,
    LIFE_DEAD   = 2'd2
  } life_state_e;

  typedef enum logic {
    DRAW_IDLE = 1'b0,
    DRAW_SCAN = 1'b1
  } draw_state_e;

  localparam logic [8:0] X_MAX      = 9'(SCREEN_W - SPRITE_W);
  localparam logic [8:0] STEP_9     = 9'(STEP);
  localparam logic [7:0] X_RESET    = 8'(START_X);
  localparam logic [6:0] Y_BASE     = 7'(START_Y);
  localparam logic [3:0] LAST_COL   = 4'(SPRITE_W - 1);
  localparam logic [3:0] LAST_ROW   = 4'(SPRITE_H - 1);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);

  life_state_e life_q, life_d;
  draw_state_e draw_q, draw_d;
  logic [7:0]  x_q, x_d;
  logic [8:0]  x_ext;
  logic [3:0]  lives_q, lives_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        invuln_q, invuln_d;
  logic        game_over_q, game_over_d;
  logic [2:0]  vis_colour;
  logic [3:0]  col_q, col_d, row_q, row_d;
  logic [7:0]  snap_x_q, snap_x_d;
  logic [2:0]  snap_colour_q, snap_colour_d;
  logic [7:0]  x_pos_q, x_pos_d;
  logic [6:0]  y_pos_q, y_pos_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        draw_busy_q, draw_busy_d;
  logic        draw_done_q, draw_done_d;

  // Horizontal movement; the clamp is done 9 bits wide so x never wraps.
  always_comb begin
    x_ext = {1'b0, x_q};
    x_d   = x_q;
    if (frame_tick && (life_q != LIFE_DEAD)) begin
      if (left && !right) begin
        if (x_ext >= STEP_9) x_d = 8'(x_ext - STEP_9);
        else                 x_d = 8'd0;
      end else if (right && !left) begin
        if ((x_ext + STEP_9) > X_MAX) x_d = X_MAX[7:0];
        else                          x_d = 8'(x_ext + STEP_9);
      end else begin
        x_d = x_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  // Life FSM: hits, invulnerability countdown and game over.
  always_comb begin
    life_d      = life_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    invuln_d    = invuln_q;
    game_over_d = game_over_q;
    case (life_q)
      LIFE_ALIVE: begin
        if (got_hit) begin
          lives_d = lives_q - 4'd1;
          if (lives_q == 4'd1) begin
            life_d      = LIFE_DEAD;
            game_over_d = 1'b1;
          end else begin
            life_d    = LIFE_INVULN;
            inv_cnt_d = INV_LOAD;
            invuln_d  = 1'b1;
          end
        end else begin
          life_d = LIFE_ALIVE;
        end
      end
      LIFE_INVULN: begin
        // Hits are ignored here; the window only counts down on frame ticks.
        if (frame_tick) begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          if (inv_cnt_q == 8'd1) begin
            life_d   = LIFE_ALIVE;
            invuln_d = 1'b0;
          end else begin
            life_d = LIFE_INVULN;
          end
        end else begin
          life_d = LIFE_INVULN;
        end
      end
      LIFE_DEAD: life_d = LIFE_DEAD;
      default:   life_d = LIFE_ALIVE;
    endcase
  end

  // Colour the ship would be drawn with right now (blinks while invulnerable).
  always_comb begin
    case (life_q)
      LIFE_ALIVE:  vis_colour = COLOUR;
      LIFE_INVULN: vis_colour = inv_cnt_q[2] ? 3'b000 : COLOUR;
      LIFE_DEAD:   vis_colour = 3'b000;
      default:     vis_colour = 3'b000;
    endcase
  end

  // Draw FSM; col_q/row_q index the pixel currently presented on the outputs.
  // Base y never changes, so only x and colour need a snapshot.
  always_comb begin
    draw_d        = draw_q;
    col_d         = col_q;
    row_d         = row_q;
    snap_x_d      = snap_x_q;
    snap_colour_d = snap_colour_q;
    plot_d        = 1'b0;
    draw_busy_d   = 1'b0;
    draw_done_d   = 1'b0;
    x_pos_d       = x_d;
    y_pos_d       = Y_BASE;
    colour_d      = 3'b000;
    case (draw_q)
      DRAW_IDLE: begin
        if (draw_req) begin
          draw_d        = DRAW_SCAN;
          col_d         = 4'd0;
          row_d         = 4'd0;
          snap_x_d      = x_q;
          snap_colour_d = vis_colour;
          plot_d        = 1'b1;
          draw_busy_d   = 1'b1;
          x_pos_d       = x_q;
          colour_d      = vis_colour;
        end else begin
          draw_d = DRAW_IDLE;
        end
      end
      DRAW_SCAN: begin
        if ((col_q == LAST_COL) && (row_q == LAST_ROW)) begin
          draw_d      = DRAW_IDLE;
          draw_done_d = 1'b1;
        end else begin
          if (col_q == LAST_COL) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
            row_d = row_q;
          end
          plot_d      = 1'b1;
          draw_busy_d = 1'b1;
          x_pos_d     = snap_x_q + {4'd0, col_d};
          y_pos_d     = Y_BASE + {3'd0, row_d};
          colour_d    = snap_colour_q;
        end
      end
      default: draw_d = DRAW_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      life_q        <= LIFE_ALIVE;
      draw_q        <= DRAW_IDLE;
      x_q           <= X_RESET;
      lives_q       <= LIVES_INIT;
      inv_cnt_q     <= 8'd0;
      invuln_q      <= 1'b0;
      game_over_q   <= 1'b0;
      col_q         <= 4'd0;
      row_q         <= 4'd0;
      snap_x_q      <= X_RESET;
      snap_colour_q <= 3'b000;
      x_pos_q       <= X_RESET;
      y_pos_q       <= Y_BASE;
      colour_q      <= 3'b000;
      plot_q        <= 1'b0;
      draw_busy_q   <= 1'b0;
      draw_done_q   <= 1'b0;
    end else begin
      life_q        <= life_d;
      draw_q        <= draw_d;
      x_q           <= x_d;
      lives_q       <= lives_d;
      inv_cnt_q     <= inv_cnt_d;
      invuln_q      <= invuln_d;
      game_over_q   <= game_over_d;
      col_q         <= col_d;
      row_q         <= row_d;
      snap_x_q      <= snap_x_d;
      snap_colour_q <= snap_colour_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      draw_busy_q   <= draw_busy_d;
      draw_done_q   <= draw_done_d;
    end
  end

  assign x_pos      = x_pos_q;
  assign y_pos      = y_pos_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign draw_busy  = draw_busy_q;
  assign draw_done  = draw_done_q;
  assign lives_left = lives_q;
  assign invuln     = invuln_q;
  assign game_over  = game_over_q;

endmodule

// File: doc/player_sprite.md
# player_sprite

Parametrised player-ship controller and pixel sequencer for the 160x120 VGA game screen. Holds the ship's top-left position and moves it horizontally once per frame, clamped to the screen. Tracks lives, with a post-hit invulnerability window in which the ship blinks. On request it streams the ship's SPRITE_W x SPRITE_H pixels, one per cycle, to the VGA write port. It sits between the input debouncers, the collision checker and the frame draw arbiter.

## Interface
- SPRITE_W, 4, sprite width in pixels (1-15)
- SPRITE_H, 4, sprite height in pixels (1-15)
- SCREEN_W, 160, screen width; maximum base x is SCREEN_W-SPRITE_W
- START_X, 78, base x after reset
- START_Y, 100, base y (fixed; never changes)
- STEP, 1, pixels moved per frame_tick (1-15)
- LIVES, 3, initial lives (1-15)
- INVULN_FRAMES, 60, frame_ticks of invulnerability after a hit (1-255)
- COLOUR, 3'b111, sprite colour when alive and visible
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame; moves and invulnerability countdown happen only on it
- left  in  1  move-left request, sampled on frame_tick
- right  in  1  move-right request, sampled on frame_tick
- got_hit  in  1  one-cycle hit pulse from the collision checker
- draw_req  in  1  one-cycle pulse: start a pixel scan
- x_pos  out  8  pixel x while plot=1, otherwise base x
- y_pos  out  7  pixel y while plot=1, otherwise base y
- colour  out  3  pixel colour while plot=1, otherwise 0
- plot  out  1  VGA write enable, one pixel per cycle
- draw_busy  out  1  scan in progress
- draw_done  out  1  one-cycle pulse after the last pixel
- lives_left  out  4  remaining lives
- invuln  out  1  invulnerability window active
- game_over  out  1  lives exhausted; sticky until reset

## Operation
- Life FSM has three states: ALIVE, INVULN and DEAD.
- Reset values: base x = START_X, base y = START_Y, colour = 0, plot = 0, draw_busy = 0, draw_done = 0, lives_left = LIVES, invuln = 0, game_over = 0. Life FSM = ALIVE; draw FSM = IDLE.
- Movement applies only on a frame_tick in ALIVE or INVULN:
  - left=1, right=0: x = max(x-STEP, 0).
  - right=1, left=0: x = min(x+STEP, SCREEN_W-SPRITE_W).
  - Both set or neither set: no move.
  - The clamp is computed in 9-bit arithmetic, so x never wraps.
- ALIVE + got_hit:
  - lives_left decrements.
  - If the result is 0: go to DEAD and set game_over.
  - Otherwise: go to INVULN, load inv_cnt = INVULN_FRAMES, set invuln=1.
- INVULN:
  - got_hit is ignored.
  - Each frame_tick decrements inv_cnt; on the tick where inv_cnt reaches 0, return to ALIVE and clear invuln.
  - Blink: visible colour is COLOUR when inv_cnt[2]=0 and 3'b000 when inv_cnt[2]=1.
- DEAD: ignores left, right and got_hit. Position freezes and visible colour is 3'b000 (the scan erases the ship).
- got_hit coincident with frame_tick: the move is applied first, then the hit; both take effect in the same cycle.
- Draw FSM has two states: IDLE and SCAN.
  - IDLE + draw_req: snapshot base x/y and the visible colour, set draw_busy, clear pixel counters, go to SCAN.
  - SCAN: plot=1 each cycle, scanning row-major (column counter inner, row counter outer).
  - Pixel coordinates are x_pos = snap_x + col and y_pos = snap_y + row.
  - After pixel (SPRITE_W-1, SPRITE_H-1), return to IDLE.
  - draw_req while in SCAN is ignored (not queued).
  - Movement or hits during SCAN update the live state only; the scan in progress uses the snapshot, so it does not tear.
- Reset mid-scan: plot, draw_busy and draw_done drop on the next edge. There is no partial-scan completion.

## Timing
- draw_req sampled high at edge t: draw_busy=1 from t+1.
- First pixel: plot=1 in cycle t+1.
- Last pixel: cycle t+SPRITE_W*SPRITE_H.
- Cycle t+SPRITE_W*SPRITE_H+1: draw_done=1, draw_busy=0, plot=0.
- Earliest accepted next draw_req is in the draw_done cycle.
- Position, lives, invuln and game_over update one edge after the sampling frame_tick or got_hit.
- All outputs are registered.

## Test plan
- Reset then draw_req:
  - plot is high for 16 consecutive cycles.
  - Pixels run (78,100),(79,100),(80,100),(81,100),(78,101)…(81,103), all with colour 3'b111.
  - draw_done pulses at cycle 17.
- Hold right for 80 frame_ticks: x saturates at 156 and stays there. Then hold left for 200 ticks: x saturates at 0. left=right=1: x unchanged.
- got_hit at lives=3:
  - lives_left=2 and invuln=1.
  - A second got_hit 10 ticks later leaves lives_left at 2.
  - A draw at inv_cnt=52 (bit2=1) gives colour 0.
  - invuln clears after exactly 60 frame_ticks.
- Three hits spaced beyond the invulnerability window:
  - game_over=1 and lives_left=0.
  - Further left/right are ignored.
  - A draw outputs 16 pixels with colour 0.
- During a scan, a frame_tick with right=1 and a second draw_req:
  - All 16 pixels use the old x.
  - The second request is dropped (only one draw_done).
  - x_pos after the scan is the old x+1.
- reset_n low at pixel 7 of a scan: plot=0 and draw_busy=0 next cycle, no draw_done, x=78, lives_left=3.
